// File: rtl/pc_stack_unit.sv
// Program counter with a small hardware return-address stack for call/return.
// PcNext is the value PcOut loads on the next edge whenever PcWe is high.
module pc_stack_unit #(
  parameter int PSize = 6,
  parameter int Depth = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             PcWe,
  input  logic [1:0]       PcSel,
  input  logic [PSize-1:0] JmpAddr,
  output logic [PSize-1:0] PcOut,
  output logic [PSize-1:0] PcNext,
  output logic             StackFull,
  output logic             StackEmpty,
  output logic             StackErr
);

  localparam int SPW = $clog2(Depth + 1);

  typedef enum logic [1:0] {
    SEL_INC  = 2'b00,
    SEL_JMP  = 2'b01,
    SEL_CALL = 2'b10,
    SEL_RET  = 2'b11
  } pc_sel_e;

  logic [PSize-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [PSize-1:0] stack_q [Depth];

  logic [PSize-1:0] pc_inc;
  logic [PSize-1:0] tos;
  logic             full, empty;
  logic             push, pop, fault;
  logic [PSize-1:0] target;

  function automatic logic [PSize-1:0] wrap_inc(input logic [PSize-1:0] v);
    return v + {{(PSize-1){1'b0}}, 1'b1};
  endfunction

  assign pc_inc = wrap_inc(pc_q);
  assign full   = (sp_q == SPW'(Depth));
  assign empty  = (sp_q == '0);

  // Top-of-stack read: entry SP-1, selected by comparing SP against each slot.
  always_comb begin
    tos = '0;
    for (int i = 0; i < Depth; i++) begin
      if (sp_q == SPW'(i + 1)) tos = stack_q[i];
    end
  end

  always_comb begin
    target = pc_inc;
    push   = 1'b0;
    pop    = 1'b0;
    fault  = 1'b0;
    case (pc_sel_e'(PcSel))
      SEL_INC: target = pc_inc;
      SEL_JMP: target = JmpAddr;
      SEL_CALL: begin
        if (full) begin
          target = pc_inc;
          fault  = 1'b1;
        end else begin
          target = JmpAddr;
          push   = 1'b1;
        end
      end
      SEL_RET: begin
        if (empty) begin
          target = pc_inc;
          fault  = 1'b1;
        end else begin
          target = tos;
          pop    = 1'b1;
        end
      end
      default: target = pc_inc;
    endcase
  end

  assign PcNext = target;

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    if (PcWe) begin
      pc_d = target;
      if (push) sp_d = sp_q + SPW'(1);
      if (pop)  sp_d = sp_q - SPW'(1);
      if (fault) err_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage is data only; Reset just blocks a push on its edge.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < Depth; i++) begin
      if (!Reset && PcWe && push && sp_q == SPW'(i)) stack_q[i] <= pc_inc;
    end
  end

  assign PcOut      = pc_q;
  assign StackFull  = full;
  assign StackEmpty = empty;
  assign StackErr   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed sequences with literal expectations plus
// randomized traffic compared every cycle against a queue-based stack model.
module tb_pc_stack_unit;
  localparam int PSIZE = 6;
  localparam int DEPTH = 4;
  localparam int MODV  = 1 << PSIZE;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             PcWe = 1'b0;
  logic [1:0]       PcSel = 2'b00;
  logic [PSIZE-1:0] JmpAddr = '0;
  logic [PSIZE-1:0] PcOut, PcNext;
  logic             StackFull, StackEmpty, StackErr;

  pc_stack_unit #(.PSize(PSIZE), .Depth(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .PcWe(PcWe), .PcSel(PcSel), .JmpAddr(JmpAddr),
    .PcOut(PcOut), .PcNext(PcNext), .StackFull(StackFull),
    .StackEmpty(StackEmpty), .StackErr(StackErr)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: PC as an integer, return stack as a queue.
  int  m_pc = 0;
  int  m_stk[$];
  bit  m_err = 0;
  bit  started = 0;

  function automatic int model_next(input int sel, input int addr);
    int inc;
    inc = (m_pc + 1) % MODV;
    case (sel)
      0: return inc;
      1: return addr;
      2: return (m_stk.size() == DEPTH) ? inc : addr;
      default: return (m_stk.size() == 0) ? inc : m_stk[m_stk.size()-1];
    endcase
  endfunction

  always @(posedge Clock) begin
    int nxt;
    if (Reset) begin
      m_pc = 0;
      m_stk.delete();
      m_err = 0;
      started = 1;
    end else if (PcWe) begin
      nxt = model_next(int'(PcSel), int'(JmpAddr));
      if (PcSel == 2'b10) begin
        if (m_stk.size() == DEPTH) m_err = 1;
        else m_stk.push_back((m_pc + 1) % MODV);
      end else if (PcSel == 2'b11) begin
        if (m_stk.size() == 0) m_err = 1;
        else void'(m_stk.pop_back());
      end
      m_pc = nxt;
    end
  end

  always @(negedge Clock) begin
    if (started) begin
      check("model PcOut", int'(PcOut), m_pc);
      check("model PcNext", int'(PcNext), model_next(int'(PcSel), int'(JmpAddr)));
      check("model StackFull", int'(StackFull), int'(m_stk.size() == DEPTH));
      check("model StackEmpty", int'(StackEmpty), int'(m_stk.size() == 0));
      check("model StackErr", int'(StackErr), int'(m_err));
    end
  end

  // Inputs are applied 2 time units after a rising edge; the op takes effect on the next edge.
  task automatic cyc(input logic we, input logic [1:0] sel, input int addr);
    PcWe    = we;
    PcSel   = sel;
    JmpAddr = PSIZE'(addr);
    @(posedge Clock);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    PcWe  = 1'b0;
    @(posedge Clock);
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    int exp_pc;
    @(posedge Clock);
    #2;
    Reset = 1'b0;

    // Reset state and full wrap of the PC
    check("reset PcOut", int'(PcOut), 0);
    check("reset Empty", int'(StackEmpty), 1);
    check("reset Full", int'(StackFull), 0);
    check("reset Err", int'(StackErr), 0);
    for (int i = 0; i < 65; i++) begin
      cyc(1'b1, 2'b00, 0);
      check("inc PcOut", int'(PcOut), (i + 1) % 64);
      check("inc Empty", int'(StackEmpty), 1);
      check("inc Err", int'(StackErr), 0);
    end
    check("inc wrap end", int'(PcOut), 1);

    // Single call / return
    do_reset();
    cyc(1'b1, 2'b01, 5);
    check("jmp 5", int'(PcOut), 5);
    cyc(1'b1, 2'b10, 20);
    check("call 20", int'(PcOut), 20);
    check("call Empty", int'(StackEmpty), 0);
    repeat (3) cyc(1'b1, 2'b00, 0);
    check("inc x3", int'(PcOut), 23);
    cyc(1'b1, 2'b11, 0);
    check("ret to 6", int'(PcOut), 6);
    check("ret Empty", int'(StackEmpty), 1);

    // Nested calls, overflow, unwind
    do_reset();
    cyc(1'b1, 2'b10, 10);
    cyc(1'b1, 2'b10, 30);
    cyc(1'b1, 2'b10, 40);
    check("nest Full early", int'(StackFull), 0);
    cyc(1'b1, 2'b10, 50);
    check("nest PcOut", int'(PcOut), 50);
    check("nest Full", int'(StackFull), 1);
    cyc(1'b1, 2'b10, 60);
    check("overflow PcOut", int'(PcOut), 51);
    check("overflow Err", int'(StackErr), 1);
    check("overflow Full", int'(StackFull), 1);
    cyc(1'b1, 2'b11, 0);
    check("ret1", int'(PcOut), 41);
    cyc(1'b1, 2'b11, 0);
    check("ret2", int'(PcOut), 31);
    cyc(1'b1, 2'b11, 0);
    check("ret3", int'(PcOut), 11);
    cyc(1'b1, 2'b11, 0);
    check("ret4", int'(PcOut), 1);
    check("unwind Empty", int'(StackEmpty), 1);
    check("unwind Err sticky", int'(StackErr), 1);

    // Underflow, sticky error
    do_reset();
    check("err cleared", int'(StackErr), 0);
    cyc(1'b1, 2'b11, 0);
    check("underflow PcOut", int'(PcOut), 1);
    check("underflow Err", int'(StackErr), 1);
    cyc(1'b1, 2'b01, 12);
    check("jmp 12", int'(PcOut), 12);
    check("err sticky", int'(StackErr), 1);

    // PcWe low: hold, PcNext still tracks selection
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 2'(i % 4), 33);
      check("hold PcOut", int'(PcOut), 12);
      check("hold Empty", int'(StackEmpty), 1);
      check("hold Err", int'(StackErr), 1);
      case (i % 4)
        0, 3:    exp_pc = 13;
        default: exp_pc = 33;
      endcase
      check("hold PcNext", int'(PcNext), exp_pc);
    end

    // Pushed return address wraps; reset beats a simultaneous call
    do_reset();
    cyc(1'b1, 2'b01, 63);
    cyc(1'b1, 2'b10, 25);
    check("call from 63", int'(PcOut), 25);
    cyc(1'b1, 2'b11, 0);
    check("ret wrap", int'(PcOut), 0);
    cyc(1'b1, 2'b01, 7);
    Reset = 1'b1;
    cyc(1'b1, 2'b10, 25);
    Reset = 1'b0;
    check("reset+call PcOut", int'(PcOut), 0);
    check("reset+call Empty", int'(StackEmpty), 1);
    cyc(1'b1, 2'b11, 0);
    check("no push on reset", int'(PcOut), 1);
    check("no push Err", int'(StackErr), 1);

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), int'($urandom_range(0, MODV - 1)));
    end
    Reset = 1'b0;
    PcWe  = 1'b0;
    @(negedge Clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program counter stage directly downstream of the instruction-sequencing control unit.
- Consumes the control unit's PC write-enable and PC-select outputs, holds the current PC, and supplies the program-memory address.
- Adds subroutine support through a small hardware return-address stack (call/return), with full/empty status and a sticky error flag.
- PC arithmetic wraps modulo 2^PSize.

Parameters:
- PSize, 6, PC / program-memory address width in bits.
- Depth, 4, return-stack entries (minimum 1).

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset; sampled on rising edge of Clock.
- PcWe  input  1  PC update enable; when low, PC and stack hold.
- PcSel  input  2  00 Inc, 01 Jmp, 10 Call, 11 Ret.
- JmpAddr  input  PSize  target address for Jmp and Call.
- PcOut  output  PSize  current PC (registered) to program memory.
- PcNext  output  PSize  combinational value PC takes at next edge if PcWe=1.
- StackFull  output  1  depth counter == Depth.
- StackEmpty  output  1  depth counter == 0.
- StackErr  output  1  sticky: overflow or underflow occurred since reset.

Behaviour:
- One clock (Clock); reset is synchronous and active-high (Reset); Reset has priority over all other inputs.
- Reset values:
  - PcOut=0, depth count=0, StackEmpty=1, StackFull=0, StackErr=0.
  - Stack contents undefined (not reset); never visible while empty.
- Storage:
  - Depth x PSize register array.
  - Depth counter SP, width clog2(Depth+1); top-of-stack entry is SP-1.
- PcWe=0: PcOut, SP, stack contents and StackErr all hold.
- PcWe=1, Inc: PcOut <= PcOut+1 (mod 2^PSize; all-ones wraps to 0). Stack untouched.
- PcWe=1, Jmp: PcOut <= JmpAddr. Stack untouched.
- PcWe=1, Call, not full:
  - stack[SP] <= PcOut+1 (wrapped); SP <= SP+1; PcOut <= JmpAddr.
- PcWe=1, Call, full (overflow):
  - No push; SP and contents unchanged.
  - PcOut <= PcOut+1; StackErr <= 1.
- PcWe=1, Ret, not empty: PcOut <= stack[SP-1]; SP <= SP-1.
- PcWe=1, Ret, empty (underflow):
  - No pop; PcOut <= PcOut+1; StackErr <= 1.
- PcNext:
  - Purely combinational from PcOut, PcSel, JmpAddr, SP and stack.
  - Equals the PcOut value the rules above would load, regardless of PcWe.
  - Reflects the reset value only after the reset edge; not gated by Reset.
- Latency:
  - PcOut changes exactly one Clock edge after a sampled PcWe=1.
  - The control unit asserts PcWe for one cycle per instruction, so one PC update per instruction.
- Flags:
  - StackFull and StackEmpty are decoded from the registered SP; they update the same edge SP changes.
  - Both flags are high only if Depth=0, which is illegal.
- StackErr is cleared only by Reset.
- Call then immediate Ret (consecutive PcWe cycles) returns to the call address + 1.
- Reset asserted mid-sequence (e.g. during a Call cycle with PcWe=1): the reset values win on that edge; no push occurs.
- Unknown/X on PcSel while PcWe=0 has no effect.

Test Plan:
- Reset, then PcWe=1 with Inc for 65 cycles (PSize=6) -> PcOut 0,1,...,63,0,1; StackEmpty=1 and StackErr=0 throughout.
- PcOut=5, Call JmpAddr=20 -> PcOut=20, SP=1; then Inc x3 -> 23; then Ret -> PcOut=6, StackEmpty=1.
- Nested: Call 10 from 0, Call 30 from 10, Call 40 from 30, Call 50 from 40 -> StackFull=1. Fifth Call 60 from 50 -> PcOut=51, StackErr=1, SP stays 4. Four Rets -> 41, 31, 11, 1.
- Reset, Ret with empty stack -> PcOut=1, StackErr=1. Then Jmp 12 -> PcOut=12, StackErr stays 1 until Reset.
- PcWe=0 for 10 cycles with PcSel toggling and JmpAddr=33 -> PcOut, SP and flags unchanged. PcNext tracks the selected value each cycle (e.g. 33 for Jmp).
- Call 25 from PcOut=63 -> pushed value 0 (wrap); then Ret -> PcOut=0. Assert Reset together with PcWe=1, Call -> PcOut=0, StackEmpty=1, no push.
